// File: rtl/urat_pkg.sv
// ----------------------------------------------------------------------------
// urat_pkg
// Shared types and constants for the URAT frame receiver.
//   urat_state_e : receiver FSM states
//   START_BIT    : line level of a valid start bit
//   STOP_BIT     : line level of a valid stop bit
//   DATA_W       : payload width
//   FRAME_W      : reconstructed frame width ({1'b0, start, data, parity, stop})
//   urat_parity  : even-style XOR parity over the payload
// ----------------------------------------------------------------------------
package urat_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } urat_state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam int   DATA_W    = 8;
    localparam int   FRAME_W   = DATA_W + 4;

    function automatic logic urat_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/urat_sync2.sv
// ----------------------------------------------------------------------------
// urat_sync2
// Two-flop synchronizer bringing the asynchronous serial line into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0 (idle level)
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk cycles of latency
// ----------------------------------------------------------------------------
module urat_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/urat_frame_rx.sv
// ----------------------------------------------------------------------------
// urat_frame_rx
// Serial receiver for the URAT frame {start=1, data[7:0] MSB first,
// parity=^data, stop=0}; the line idles at 0. Each bit is sampled once at
// mid-bit, the frame is rebuilt and checked, and the byte is presented with a
// one-cycle valid pulse.
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx_in      : serial line, asynchronous to clk
//   data_out   : last received byte, held until the next frame completes
//   frame_out  : {1'b0, start, data, parity, stop} as received
//   data_valid : one-cycle pulse when data_out/frame_out/flags are updated
//   parity_err : parity of data_out differs from the received parity bit
//   frame_err  : received stop bit was not STOP_BIT
//   busy       : high in every state except IDLE
//
// Handshake: data_valid is a pure strobe with no ready/back-pressure; the
// consumer must take data_out/frame_out/flags in the cycle data_valid is high
// (they stay held afterwards until the next frame overwrites them).
// ----------------------------------------------------------------------------
module urat_frame_rx
    import urat_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    output logic [DATA_W-1:0]  data_out,
    output logic [FRAME_W-1:0] frame_out,
    output logic               data_valid,
    output logic               parity_err,
    output logic               frame_err,
    output logic               busy
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA_BIT = 4'(DATA_W);

    logic rx_s;

    urat_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    urat_state_e           state_q, state_d;
    logic [CW-1:0]         clk_cnt_q;
    logic [3:0]            bit_cnt_q;
    // Holds start, data MSB..LSB and parity; the stop bit is taken straight
    // from the line at the final sample.
    logic [DATA_W+1:0]     shift_q;
    logic                  armed_q;

    logic                  tick;
    logic                  sample_en;
    logic                  glitch;
    logic                  frame_done;

    // The start bit is sampled half a bit in; every later bit one full bit
    // after the previous sample, which lands each sample at mid-bit.
    always_comb begin
        tick = 1'b0;
        if (state_q == START) tick = (clk_cnt_q == HALF_M1);
        else                  tick = (clk_cnt_q == FULL_M1);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (armed_q && rx_s == START_BIT) state_d = START;
            START:  if (tick) state_d = (rx_s == START_BIT) ? DATA : IDLE;
            DATA:   if (tick && bit_cnt_q == LAST_DATA_BIT) state_d = PARITY;
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        busy       = (state_q != IDLE);
        sample_en  = (state_q != IDLE) && tick;
        glitch     = (state_q == START) && tick && (rx_s != START_BIT);
        frame_done = (state_q == STOP) && tick;
    end

    // ---------------- bit timer, shift register, arming ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            // Held at 0 in IDLE so it is already cleared on entry to START.
            if (state_q == IDLE || tick) clk_cnt_q <= '0;
            else                         clk_cnt_q <= clk_cnt_q + CW'(1);

            if (state_q == IDLE)  bit_cnt_q <= '0;
            else if (frame_done)  bit_cnt_q <= '0;
            else if (sample_en)   bit_cnt_q <= bit_cnt_q + 4'd1;

            if (sample_en && !frame_done) shift_q <= {shift_q[DATA_W:0], rx_s};

            // Arming requires seeing the idle level first, so a line stuck at
            // 1 (e.g. after a bad stop bit) cannot start a new frame.
            if (state_q == IDLE) begin
                if (rx_s != START_BIT) armed_q <= 1'b1;
                else if (armed_q)      armed_q <= 1'b0;
            end else if (glitch) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            frame_out  <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= frame_done;
            if (frame_done) begin
                data_out   <= shift_q[DATA_W:1];
                frame_out  <= {1'b0, shift_q, rx_s};
                parity_err <= (urat_parity(shift_q[DATA_W:1]) != shift_q[0]);
                frame_err  <= (rx_s != STOP_BIT);
            end
        end
    end

endmodule
